conv_encoder_framer: RTL and testbench

- Rate-1/2, constraint-length-3 convolutional encoder with frame control and zero-tail termination.
- Produces the `en` / `d_in[1:0]` symbol stream consumed by viterbi_decoder_top, which is its decoder pair.
- Takes a serial bit stream through a valid/ready handshake and encodes FRAME_LEN data bits per frame.
- Appends 2 flush symbols per frame so the trellis returns to state 00, giving the decoder a known end state.

---
 rtl/conv_encoder_framer.sv | 171 +++++++++++++++++
 tb/tb_conv_encoder_framer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_framer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_encoder_framer
//  Purpose  : Rate-1/2, K=3 convolutional encoder with frame control and
//             zero-tail termination. Accepts FRAME_LEN serial bits per frame
//             over a valid/ready handshake. It then appends two zero-input
//             flush symbols, so the trellis ends in state 00.
//  Ports    : clk        - system clock, rising edge
//             rst_n      - asynchronous active-low reset
//             start      - one-cycle frame open pulse, honoured in IDLE only
//             s_valid    - input bit valid
//             s_data     - input data bit
//             s_ready    - encoder accepts s_data this cycle (DATA state)
//             enc_valid  - enc_out valid (feeds decoder en)
//             enc_out    - coded symbol {g0,g1} (feeds decoder d_in)
//             busy       - high in any state other than IDLE
//             frame_done - pulse coincident with the last tail symbol
//  Optional : CONV_ENC_ERR_INJ_EN adds err_en / err_pos / err_mask. These
//             corrupt one output symbol per frame with an XOR mask. The
//             encoder state is not affected.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_encoder_framer #(
   parameter int         FRAME_LEN = 16,
   parameter logic [2:0] G0        = 3'b111,
   parameter logic [2:0] G1        = 3'b101,
   parameter int         CNT_W     = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             s_valid,
   input  logic             s_data,
`ifdef CONV_ENC_ERR_INJ_EN
   input  logic             err_en,
   input  logic [CNT_W-1:0] err_pos,
   input  logic [1:0]       err_mask,
`endif
   output logic             s_ready,
   output logic             enc_valid,
   output logic [1:0]       enc_out,
   output logic             busy,
   output logic             frame_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(1);

   state_t           state, state_nxt;
   logic [1:0]       sreg, sreg_nxt;     // sreg[1] = newest past bit
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             valid_nxt;
   logic [1:0]       out_nxt;
   logic             done_nxt;
   logic             encode;
   logic             u;
   logic [2:0]       taps;
   logic [1:0]       inj;

`ifdef CONV_ENC_ERR_INJ_EN
   localparam logic [CNT_W-1:0] TAIL_BASE = CNT_W'(FRAME_LEN);

   logic             err_arm;
   logic [CNT_W-1:0] err_pos_q;
   logic [1:0]       err_mask_q;
   logic [CNT_W-1:0] sym_idx;

   // Frame-relative index of the symbol being registered this cycle. Tail
   // symbols continue the numbering after the data symbols.
   assign sym_idx = (state == TAIL) ? (cnt + TAIL_BASE) : cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_arm    <= 1'b0;
         err_pos_q  <= '0;
         err_mask_q <= 2'b00;
      end else if (state == IDLE && start) begin
         err_arm    <= err_en;
         err_pos_q  <= err_pos;
         err_mask_q <= err_mask;
      end
   end

   // sym_idx only spans 0..FRAME_LEN+1, so out-of-range positions never hit.
   assign inj = (err_arm && encode && sym_idx == err_pos_q) ? err_mask_q : 2'b00;
`else
   assign inj = 2'b00;
`endif

   assign s_ready = (state == DATA);
   assign busy    = (state != IDLE);
   assign taps    = {u, sreg};

   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      cnt_nxt   = cnt;
      valid_nxt = 1'b0;
      out_nxt   = enc_out;   // holds while enc_valid is low
      done_nxt  = 1'b0;
      encode    = 1'b0;
      u         = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               sreg_nxt  = 2'b00;
               cnt_nxt   = '0;
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (s_valid) begin
               encode = 1'b1;
               u      = s_data;
               if (cnt == LAST_DATA) begin
                  cnt_nxt   = '0;
                  state_nxt = TAIL;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         TAIL: begin
            // Zero input for two cycles flushes both memory cells.
            encode = 1'b1;
            u      = 1'b0;
            if (cnt == LAST_TAIL) begin
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (encode) begin
         valid_nxt = 1'b1;
         out_nxt   = {^(taps & G0), ^(taps & G1)} ^ inj;
         sreg_nxt  = {u, sreg[1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sreg       <= 2'b00;
         cnt        <= '0;
         enc_valid  <= 1'b0;
         enc_out    <= 2'b00;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         sreg       <= sreg_nxt;
         cnt        <= cnt_nxt;
         enc_valid  <= valid_nxt;
         enc_out    <= out_nxt;
         frame_done <= done_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_conv_encoder_framer
//  Purpose  : Self-checking bench for conv_encoder_framer. It uses one
//             instance with FRAME_LEN=4 and one with FRAME_LEN=16. Expected
//             symbols come from a hand-derived vector table and from a
//             convolution model of the generator polynomials.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_encoder_framer;

   localparam logic [2:0] G0_REF = 3'b111;
   localparam logic [2:0] G1_REF = 3'b101;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       start4 = 1'b0, start16 = 1'b0, s_valid = 1'b0, s_data = 1'b0;
   logic       rdy4, v4, busy4, done4;
   logic [1:0] out4;
   logic       rdy16, v16, busy16, done16;
   logic [1:0] out16;
`ifdef CONV_ENC_ERR_INJ_EN
   logic       err_en = 1'b0;
   logic [9:0] err_pos = '0;
   logic [1:0] err_mask = '0;
`endif

   conv_encoder_framer #(.FRAME_LEN(4), .G0(3'b111), .G1(3'b101), .CNT_W(10)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .s_valid(s_valid), .s_data(s_data),
`ifdef CONV_ENC_ERR_INJ_EN
      .err_en(err_en), .err_pos(err_pos), .err_mask(err_mask),
`endif
      .s_ready(rdy4), .enc_valid(v4), .enc_out(out4), .busy(busy4), .frame_done(done4));

   conv_encoder_framer #(.FRAME_LEN(16), .G0(3'b111), .G1(3'b101), .CNT_W(10)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .s_valid(s_valid), .s_data(s_data),
`ifdef CONV_ENC_ERR_INJ_EN
      .err_en(1'b0), .err_pos(10'd0), .err_mask(2'b00),
`endif
      .s_ready(rdy16), .enc_valid(v16), .enc_out(out16), .busy(busy16), .frame_done(done16));

   // ---------------------------------------------------------------- monitor
   typedef struct { logic [1:0] sym; logic done; int cyc; } obs_t;
   typedef obs_t       obs_q_t[$];
   typedef logic [1:0] sym_q_t[$];
   typedef bit         bit_q_t[$];

   int     cyc = 0;
   obs_q_t q4, q16;
   int     busy16_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (v4 === 1'b1)     q4.push_back('{out4, done4, cyc});
      if (v16 === 1'b1)    q16.push_back('{out16, done16, cyc});
      if (busy16 === 1'b1) busy16_cyc.push_back(cyc);
   end

   // ---------------------------------------------------------------- checks
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: each coded bit is the GF(2) convolution of the input bit
   // sequence (zero-extended by two tail bits) with the generator taps.
   function automatic logic [1:0] model_sym(input bit_q_t bits, input int k);
      bit b [3];
      for (int j = 0; j < 3; j++)
         b[j] = (k - j >= 0 && k - j < bits.size()) ? bits[k-j] : 1'b0;
      return {(G0_REF[2] & b[0]) ^ (G0_REF[1] & b[1]) ^ (G0_REF[0] & b[2]),
              (G1_REF[2] & b[0]) ^ (G1_REF[1] & b[1]) ^ (G1_REF[0] & b[2])};
   endfunction

   function automatic sym_q_t model_frame(input bit_q_t bits);
      sym_q_t r;
      for (int k = 0; k < bits.size() + 2; k++) r.push_back(model_sym(bits, k));
      return r;
   endfunction

   task automatic check_frame(input string name, input obs_q_t q, input sym_q_t exp,
                              input bit contiguous);
      check({name, "_len"}, q.size(), exp.size());
      if (q.size() == exp.size()) begin
         foreach (exp[k]) begin
            check($sformatf("%s_sym%0d", name, k), int'(q[k].sym), int'(exp[k]));
            check($sformatf("%s_done%0d", name, k), int'(q[k].done),
                  (k == exp.size() - 1) ? 1 : 0);
            if (contiguous && k > 0)
               check($sformatf("%s_cyc%0d", name, k), q[k].cyc - q[k-1].cyc, 1);
         end
      end
   endtask

   // Called on a negedge with the target encoder in IDLE. Returns on the
   // negedge after the last data bit was accepted.
   task automatic send(input bit sel16, input bit_q_t bits, input int gap_at,
                       input int gap_len, input int rnd_gap, input int start_mid);
      if (sel16) start16 = 1'b1; else start4 = 1'b1;
      @(negedge clk);
      start4  = 1'b0;
      start16 = 1'b0;
      foreach (bits[i]) begin
         int g;
         int t;
         g = (i == gap_at) ? gap_len :
             ((rnd_gap > 0 && i > 0) ? int'($urandom_range(rnd_gap, 0)) : 0);
         s_valid = 1'b0;
         repeat (g) begin
            @(negedge clk);
            if (i == gap_at) check("gap_ready_high", int'(sel16 ? rdy16 : rdy4), 1);
         end
         s_valid = 1'b1;
         s_data  = bits[i];
         if (i == start_mid) start4 = 1'b1;
         t = 0;
         while ((sel16 ? rdy16 : rdy4) !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
         end
         check("ready_seen", int'(sel16 ? rdy16 : rdy4), 1);
         @(negedge clk);
         start4 = 1'b0;
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_done(input bit sel16, input int budget);
      int t = 0;
      while ((sel16 ? done16 : done4) !== 1'b1 && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("frame_done_seen", int'(sel16 ? done16 : done4), 1);
   endtask

   function automatic bit_q_t unpack4(input logic [3:0] v);
      bit_q_t r;
      for (int k = 0; k < 4; k++) r.push_back(v[3-k]);  // MSB is first bit
      return r;
   endfunction

   // ---------------------------------------------------------------- test
   typedef struct { logic [3:0] bits; logic [11:0] exp; } vec_t;
   vec_t tbl [5];

   initial begin : main
      bit_q_t bits;
      sym_q_t exp;
      obs_q_t tmp;
      int     c0, d, nb;

      // Symbols listed first-to-last: {s0,s1,s2,s3,s4,s5}.
      tbl[0] = '{4'b1011, 12'b11_10_00_01_01_11};
      tbl[1] = '{4'b0000, 12'b00_00_00_00_00_00};
      tbl[2] = '{4'b1000, 12'b11_10_11_00_00_00};
      tbl[3] = '{4'b1111, 12'b11_01_10_10_01_11};
      tbl[4] = '{4'b0101, 12'b00_11_10_00_10_11};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_s_ready",    int'(rdy4),  0);
      check("rst_enc_valid",  int'(v4),    0);
      check("rst_enc_out",    int'(out4),  0);
      check("rst_busy",       int'(busy4), 0);
      check("rst_frame_done", int'(done4), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven frames, s_valid held high
      for (int e = 0; e < 5; e++) begin
         bits = unpack4(tbl[e].bits);
         exp.delete();
         for (int k = 0; k < 6; k++) exp.push_back(tbl[e].exp[11-2*k -: 2]);
         q4.delete();
         send(1'b0, bits, -1, 0, 0, -1);
         wait_done(1'b0, 20);
         #1;
         check_frame($sformatf("tbl%0d", e), q4, exp, 1'b1);
         @(negedge clk);
      end

      // Three-cycle gap between bit 2 and bit 3
      bits = unpack4(4'b1011);
      q4.delete();
      send(1'b0, bits, 2, 3, 0, -1);
      wait_done(1'b0, 20);
      #1;
      check_frame("gap", q4, model_frame(bits), 1'b0);
      if (q4.size() == 6) begin
         check("gap_cyc_b1", q4[1].cyc - q4[0].cyc, 1);
         check("gap_cyc_b2", q4[2].cyc - q4[1].cyc, 4);
         check("gap_cyc_tail", q4[5].cyc - q4[2].cyc, 3);
      end
      @(negedge clk);

      // start pulsed during DATA and across both TAIL cycles
      q4.delete();
      send(1'b0, bits, -1, 0, 0, 2);
      start4 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start4 = 1'b0;
      wait_done(1'b0, 20);
      #1;
      check_frame("start_ign", q4, model_frame(bits), 1'b1);
      repeat (5) @(negedge clk);
      check("start_ign_idle_busy", int'(busy4), 0);
      check("start_ign_no_more", q4.size(), 6);

      // Reset after two accepted bits
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      s_valid = 1'b1;
      s_data  = 1'b1;
      @(negedge clk);
      s_data = 1'b0;
      @(negedge clk);
      s_valid = 1'b0;
      rst_n   = 1'b0;
      #1;
      check("arst_enc_valid",  int'(v4),    0);
      check("arst_s_ready",    int'(rdy4),  0);
      check("arst_busy",       int'(busy4), 0);
      check("arst_enc_out",    int'(out4),  0);
      check("arst_frame_done", int'(done4), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      q4.delete();
      send(1'b0, bits, -1, 0, 0, -1);
      wait_done(1'b0, 20);
      #1;
      check_frame("post_rst", q4, model_frame(bits), 1'b1);
      @(negedge clk);

      // Back-to-back frames: second start in the first IDLE cycle
      q4.delete();
      send(1'b0, unpack4(4'b1011), -1, 0, 0, -1);
      wait_done(1'b0, 20);
      send(1'b0, unpack4(4'b1111), -1, 0, 0, -1);
      wait_done(1'b0, 20);
      #1;
      check("b2b_len", q4.size(), 12);
      if (q4.size() == 12) begin
         check("b2b_gap", q4[6].cyc - q4[5].cyc, 2);
         check("b2b_first_done", int'(q4[5].done), 1);
         tmp.delete();
         for (int k = 6; k < 12; k++) tmp.push_back(q4[k]);
         check_frame("b2b_second", tmp, model_frame(unpack4(4'b1111)), 1'b1);
      end
      @(negedge clk);

      // FRAME_LEN=16, all zeros, busy window
      bits.delete();
      for (int k = 0; k < 16; k++) bits.push_back(1'b0);
      q16.delete();
      busy16_cyc.delete();
      c0 = cyc;
      send(1'b1, bits, -1, 0, 0, -1);
      wait_done(1'b1, 40);
      d = cyc;
      #1;
      check_frame("f16", q16, model_frame(bits), 1'b1);
      check("f16_done_cycle", d - c0, 19);
      nb = 0;
      foreach (busy16_cyc[k])
         if (busy16_cyc[k] >= c0 + 1 && busy16_cyc[k] <= d - 1) nb++;
      check("f16_busy_span", nb, d - 1 - c0);
      @(negedge clk);
      check("f16_busy_low_after", int'(busy16), 0);

      // Randomized frames with random gaps against the model
      for (int f = 0; f < 20; f++) begin
         bits.delete();
         for (int k = 0; k < 4; k++) bits.push_back(bit'($urandom_range(1, 0)));
         q4.delete();
         send(1'b0, bits, -1, 0, 3, -1);
         wait_done(1'b0, 40);
         #1;
         check_frame($sformatf("rnd%0d", f), q4, model_frame(bits), 1'b0);
         @(negedge clk);
      end

`ifdef CONV_ENC_ERR_INJ_EN
      // Error injection: data symbol, tail symbol, out-of-range position
      for (int c = 0; c < 3; c++) begin
         int         pos;
         logic [1:0] msk;
         pos = (c == 0) ? 2 : ((c == 1) ? 5 : 9);
         msk = (c == 0) ? 2'b10 : 2'b11;
         bits = unpack4(4'b1011);
         exp  = model_frame(bits);
         if (pos < exp.size()) exp[pos] = exp[pos] ^ msk;
         err_en   = 1'b1;
         err_pos  = 10'(pos);
         err_mask = msk;
         q4.delete();
         send(1'b0, bits, -1, 0, 0, -1);
         err_en = 1'b0;
         wait_done(1'b0, 20);
         #1;
         check_frame($sformatf("errinj%0d", c), q4, exp, 1'b1);
         @(negedge clk);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
